// File: rtl/calc_op_sequencer.sv
// Key-stream controller for the calculator's registered 4-bit add/subtract datapath.
// Define CALC_CHAIN_EN to let an operator in IDLE reuse the previous result as operand A.
module calc_op_sequencer #(
  parameter int ADDER_LAT = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [1:0] in_kind,
  input  logic [3:0] in_data,
  output logic       in_ready,
  output logic [3:0] add_a,
  output logic [3:0] add_b,
  output logic       add_binvert,
  input  logic [4:0] add_cout,
  output logic       res_valid,
  output logic [4:0] res_value,
  output logic       res_neg,
  output logic       err
);

  typedef enum logic [2:0] {
    S_IDLE, S_GOT_A, S_GOT_OP, S_GOT_B, S_EXEC, S_DONE
  } state_t;

  localparam logic [1:0] K_DIGIT = 2'b00;
  localparam logic [1:0] K_MINUS = 2'b10;
  localparam logic [1:0] K_EQ    = 2'b11;

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [3:0] add_a_q, add_a_d, add_b_q, add_b_d;
  logic       binv_q, binv_d;
  logic [4:0] res_value_q, res_value_d;
  logic       res_neg_q, res_neg_d;
  logic       res_valid_q, res_valid_d;
  logic       err_q, err_d;
  logic       in_ready_q, in_ready_d;
  logic       chain_q, chain_d;

  logic accept, is_digit, is_op, is_eq, bad_key;

  assign accept   = in_valid & in_ready_q;
  assign is_digit = (in_kind == K_DIGIT);
  assign is_eq    = (in_kind == K_EQ);
  assign is_op    = !is_digit && !is_eq;

  // NOTE: async reset clears every flop; all sequential state uses non-blocking assignments.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      add_a_q     <= '0;
      add_b_q     <= '0;
      binv_q      <= 1'b0;
      res_value_q <= '0;
      res_neg_q   <= 1'b0;
      res_valid_q <= 1'b0;
      err_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      chain_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      add_a_q     <= add_a_d;
      add_b_q     <= add_b_d;
      binv_q      <= binv_d;
      res_value_q <= res_value_d;
      res_neg_q   <= res_neg_d;
      res_valid_q <= res_valid_d;
      err_q       <= err_d;
      in_ready_q  <= in_ready_d;
      chain_q     <= chain_d;
    end
  end

  // NOTE: every comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    add_a_d     = add_a_q;
    add_b_d     = add_b_q;
    binv_d      = binv_q;
    res_value_d = res_value_q;
    res_neg_d   = res_neg_q;
    chain_d     = chain_q;
    bad_key     = 1'b0;

    case (state_q)
      S_IDLE: if (accept) begin
        if (is_digit) begin
          add_a_d = in_data;
          state_d = S_GOT_A;
        end else begin
`ifdef CALC_CHAIN_EN
          if (is_op && chain_q && !res_neg_q && (res_value_q <= 5'd15)) begin
            add_a_d = res_value_q[3:0];
            binv_d  = (in_kind == K_MINUS);
            state_d = S_GOT_OP;
          end else begin
            bad_key = 1'b1;
          end
`else
          bad_key = 1'b1;
`endif
        end
      end
      S_GOT_A: if (accept) begin
        if (is_digit) begin
          add_a_d = in_data;
        end else if (is_op) begin
          binv_d  = (in_kind == K_MINUS);
          state_d = S_GOT_OP;
        end else begin
          bad_key = 1'b1;
        end
      end
      S_GOT_OP: if (accept) begin
        if (is_digit) begin
          add_b_d = in_data;
          state_d = S_GOT_B;
        end else if (is_op) begin
          binv_d = (in_kind == K_MINUS);
        end else begin
          bad_key = 1'b1;
        end
      end
      S_GOT_B: if (accept) begin
        if (is_digit) begin
          add_b_d = in_data;
        end else if (is_op) begin
          binv_d = (in_kind == K_MINUS);
        end else begin
          cnt_d   = '0;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        cnt_d = cnt_q + 3'd1;
        // Operands were stable before equals, so cout is valid on this edge.
        if (cnt_q == 3'(ADDER_LAT - 1)) begin
          res_neg_d   = binv_q & add_cout[4];
          res_value_d = res_neg_d ? (~add_cout + 5'd1) : add_cout;
          chain_d     = 1'b1;
          state_d     = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (bad_key) begin
      state_d = S_IDLE;
      add_a_d = '0;
      add_b_d = '0;
      binv_d  = 1'b0;
      chain_d = 1'b0;
    end
`ifndef CALC_CHAIN_EN
    chain_d = 1'b0;
`endif
  end

  always_comb begin
    err_d       = bad_key;
    res_valid_d = (state_d == S_DONE);
    in_ready_d  = !((state_d == S_EXEC) || (state_d == S_DONE));
  end

  assign in_ready    = in_ready_q;
  assign add_a       = add_a_q;
  assign add_b       = add_b_q;
  assign add_binvert = binv_q;
  assign res_valid   = res_valid_q;
  assign res_value   = res_value_q;
  assign res_neg     = res_neg_q;
  assign err         = err_q;

endmodule

// File: tb/tb_calc_op_sequencer.sv
// Directed bench for calc_op_sequencer with a 2-stage registered add/subtract datapath model.
module tb_calc_op_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [1:0] in_kind;
  logic [3:0] in_data;
  logic       in_ready;
  logic [3:0] add_a, add_b;
  logic       add_binvert;
  logic [4:0] add_cout;
  logic       res_valid;
  logic [4:0] res_value;
  logic       res_neg;
  logic       err;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [1:0] DIG = 2'b00, PLUS = 2'b01, MINUS = 2'b10, EQ = 2'b11;

  calc_op_sequencer #(.ADDER_LAT(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_kind(in_kind), .in_data(in_data),
    .in_ready(in_ready), .add_a(add_a), .add_b(add_b), .add_binvert(add_binvert),
    .add_cout(add_cout), .res_valid(res_valid), .res_value(res_value),
    .res_neg(res_neg), .err(err)
  );

  always #5 clk = ~clk;

  // Datapath: 5-bit two's complement sum or difference, two register stages.
  logic [4:0] dp_s1, dp_s2;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dp_s1 <= '0;
      dp_s2 <= '0;
    end else begin
      dp_s1 <= add_binvert ? ({1'b0, add_a} - {1'b0, add_b}) : ({1'b0, add_a} + {1'b0, add_b});
      dp_s2 <= dp_s1;
    end
  end
  assign add_cout = dp_s2;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic key(input logic [1:0] k, input logic [3:0] d);
    @(negedge clk);
    in_valid = 1'b1;
    in_kind  = k;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic op(input logic [3:0] a, input logic [1:0] k, input logic [3:0] b);
    key(DIG, a);
    key(k, 4'd0);
    key(DIG, b);
    key(EQ, 4'd0);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_kind = 2'b00;
    in_data = 4'd0;
    #12;
    check("rst_in_ready", 8'(in_ready), 8'd1);
    check("rst_a", 8'(add_a), 8'd0);
    check("rst_res_valid", 8'(res_valid), 8'd0);
    check("rst_err", 8'(err), 8'd0);
    @(negedge clk);
    rst = 1'b0;

    // 7 + 5
    op(4'd7, PLUS, 4'd5);
    check("add_a_7", 8'(add_a), 8'd7);
    check("add_b_5", 8'(add_b), 8'd5);
    check("binv_plus", 8'(add_binvert), 8'd0);
    check("exec_not_ready", 8'(in_ready), 8'd0);
    tick();
    check("lat_cycle1", 8'(res_valid), 8'd0);
    tick();
    check("lat_cycle2_valid", 8'(res_valid), 8'd1);
    check("sum_12", 8'(res_value), 8'd12);
    check("sum_12_neg", 8'(res_neg), 8'd0);
    tick();
    check("valid_one_cycle", 8'(res_valid), 8'd0);
    check("ready_after_done", 8'(in_ready), 8'd1);
    check("value_held", 8'(res_value), 8'd12);

    // 3 - 9 = -6
    op(4'd3, MINUS, 4'd9);
    tick();
    tick();
    check("neg_valid", 8'(res_valid), 8'd1);
    check("neg_value_6", 8'(res_value), 8'd6);
    check("neg_flag", 8'(res_neg), 8'd1);
    tick();
    check("neg_valid_drop", 8'(res_valid), 8'd0);

    // 15 + 15 = 30, 9 - 9 = 0
    op(4'd15, PLUS, 4'd15);
    tick();
    tick();
    check("max_30", 8'(res_value), 8'd30);
    tick();
    op(4'd9, MINUS, 4'd9);
    tick();
    tick();
    check("zero_value", 8'(res_value), 8'd0);
    check("zero_neg", 8'(res_neg), 8'd0);
    tick();

    // Overwrites, then keys offered during EXEC/DONE are ignored
    key(DIG, 4'd4);
    key(DIG, 4'd9);
    key(PLUS, 4'd0);
    key(MINUS, 4'd0);
    key(DIG, 4'd2);
    key(DIG, 4'd8);
    key(EQ, 4'd0);
    check("ovr_a", 8'(add_a), 8'd9);
    check("ovr_binv", 8'(add_binvert), 8'd1);
    check("ovr_b", 8'(add_b), 8'd8);
    in_valid = 1'b1;
    in_kind  = DIG;
    in_data  = 4'd3;
    tick();
    check("exec_key_ignored", 8'(add_b), 8'd8);
    tick();
    check("ovr_valid", 8'(res_valid), 8'd1);
    check("ovr_value_1", 8'(res_value), 8'd1);
    check("ovr_neg", 8'(res_neg), 8'd0);
    tick();
    in_valid = 1'b0;
    check("done_key_ignored_a", 8'(add_a), 8'd9);
    check("done_key_no_err", 8'(err), 8'd0);

    // Protocol errors
    key(EQ, 4'd0);
    check("eq_idle_err", 8'(err), 8'd1);
    check("eq_idle_clears_a", 8'(add_a), 8'd0);
    check("eq_idle_ready", 8'(in_ready), 8'd1);
    tick();
    check("err_one_cycle", 8'(err), 8'd0);
    key(DIG, 4'd5);
    check("idle_kept_digit", 8'(add_a), 8'd5);
    key(EQ, 4'd0);
    check("got_a_eq_err", 8'(err), 8'd1);
    check("got_a_eq_a0", 8'(add_a), 8'd0);
    key(PLUS, 4'd0);
    check("plus_idle_err", 8'(err), 8'd1);
    key(DIG, 4'd2);
    key(MINUS, 4'd0);
    key(EQ, 4'd0);
    check("got_op_eq_err", 8'(err), 8'd1);
    check("got_op_eq_binv0", 8'(add_binvert), 8'd0);

    // Reset during EXEC
    op(4'd7, PLUS, 4'd5);
    tick();
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_a", 8'(add_a), 8'd0);
    check("mid_rst_b", 8'(add_b), 8'd0);
    check("mid_rst_ready", 8'(in_ready), 8'd1);
    check("mid_rst_value", 8'(res_value), 8'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("no_valid_after_rst", 8'(res_valid), 8'd0);
    end

`ifdef CALC_CHAIN_EN
    // 6 + 4 = 10, then - 3 chained = 7
    op(4'd6, PLUS, 4'd4);
    tick();
    tick();
    check("chain_first_10", 8'(res_value), 8'd10);
    tick();
    key(MINUS, 4'd0);
    check("chain_a_10", 8'(add_a), 8'd10);
    check("chain_binv", 8'(add_binvert), 8'd1);
    check("chain_no_err", 8'(err), 8'd0);
    key(DIG, 4'd3);
    key(EQ, 4'd0);
    tick();
    tick();
    check("chain_result_7", 8'(res_value), 8'd7);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/calc_op_sequencer.md
Name: calc_op_sequencer

Overview:
- Controller for the calculator's registered 4-bit add/subtract datapath (A, B, Binvert in; 5-bit cout out; 2-cycle latency).
- Collects a key stream of digit, operator and equals from the keypad decoder.
- Drives the datapath's operand and mode inputs and holds them stable for the full datapath latency.
- Captures the result, converts it to sign/magnitude and reports it with a one-cycle valid pulse.

Parameters:
- ADDER_LAT, 2: cycles from equals acceptance to datapath cout being valid. Legal range 2..7.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  key strobe
- in_kind  in  2  00 = digit, 01 = plus, 10 = minus, 11 = equals
- in_data  in  4  digit value, meaningful only when in_kind = 00
- in_ready  out  1  key accepted on an edge where in_valid & in_ready
- add_a  out  4  to datapath A
- add_b  out  4  to datapath B
- add_binvert  out  1  to datapath Binvert: 1 = subtract
- add_cout  in  5  from datapath cout
- res_valid  out  1  one-cycle result pulse
- res_value  out  5  result magnitude, 0..30
- res_neg  out  1  result is negative
- err  out  1  one-cycle protocol error pulse

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high.
- Reset values:
  - state = IDLE, in_ready = 1.
  - add_a, add_b, add_binvert, res_value, res_neg, res_valid, err all 0.
- All outputs are registered.
- Keys offered while in_ready = 0 are ignored: not latched, not an error.
- States and transitions (on accepted keys):
  - IDLE: digit -> add_a <= in_data, go GOT_A. Operator or equals -> err.
  - GOT_A: digit -> replaces add_a. Plus/minus -> add_binvert <= (kind == minus), go GOT_OP. Equals -> err.
  - GOT_OP: digit -> add_b <= in_data, go GOT_B. Operator -> replaces add_binvert, stays. Equals -> err.
  - GOT_B: digit -> replaces add_b. Operator -> replaces add_binvert. Equals -> go EXEC, clear wait counter.
  - EXEC: in_ready = 0. Counter increments each cycle. On the edge where the counter reaches ADDER_LAT-1, capture add_cout and go DONE.
  - DONE: in_ready = 0, res_valid = 1 for exactly this cycle. Next edge -> IDLE.
- Error handling: err = 1 for one cycle after the offending edge. On the same edge, state goes to IDLE and add_a, add_b, add_binvert clear to 0.
- Stability: add_a, add_b and add_binvert change only on accepted digit/operator keys or on error. They are held constant through EXEC and DONE.
- Latency: res_valid rises exactly ADDER_LAT cycles after the edge that accepted equals.
- Result conversion:
  - add_binvert = 0: res_value = add_cout, res_neg = 0.
  - add_binvert = 1 and add_cout[4] = 1: res_neg = 1, res_value = (~add_cout + 1) mod 32.
  - add_binvert = 1 and add_cout[4] = 0: res_neg = 0, res_value = add_cout.
- res_value and res_neg hold until the next capture or reset.
- Reset mid-operation (any state, including EXEC/DONE): immediate return to reset values. No res_valid pulse for the aborted operation.
- An operand value of 0 is legal everywhere. No divide or overflow cases exist: range is -15..+30.

Optional Feature:
- Macro: CALC_CHAIN_EN.
- Defined: in IDLE after a completed operation, a plus/minus key chains the last result as the new A.
  - Allowed only if res_neg = 0 and res_value <= 15: add_a <= res_value[3:0], set add_binvert, go GOT_OP.
  - Otherwise err.
  - A chain flag, cleared by reset or by any error, marks that a result exists.
- Not defined: an operator key in IDLE is always err. No chain flag exists.

Test Plan:
- 7, plus, 5, equals -> add_a = 7, add_b = 5, add_binvert = 0; res_valid exactly 2 cycles after equals; res_value = 12, res_neg = 0.
- 3, minus, 9, equals -> add_cout = 5'b11010; res_value = 6, res_neg = 1, one-cycle res_valid.
- 15, plus, 15, equals -> res_value = 30. Also 9, minus, 9 -> res_value = 0, res_neg = 0.
- Overwrite: 4, 9, plus, minus, 2, 8, equals -> add_a = 9, add_binvert = 1, add_b = 8; res_value = 1, res_neg = 0. Keys pulsed during EXEC/DONE are ignored.
- Errors: equals in IDLE -> err pulse, state stays IDLE. 5, equals -> err, add_a = 0. With CALC_CHAIN_EN undefined, plus in IDLE -> err.
- rst asserted mid-EXEC -> all outputs 0 immediately, in_ready = 1, no res_valid. With CALC_CHAIN_EN defined: 6 plus 4 = 10, then minus, 3, equals -> res_value = 7.
